// File: rtl/clock_pkg.sv
// Shared encodings, field limits and widths for the clock/set controller.
// States 4 and 5 are only reachable when the design is built with ALARM_EN.
package clock_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN         = 3'd0,
        ST_SET_HOUR    = 3'd1,
        ST_SET_MIN     = 3'd2,
        ST_SET_SEC     = 3'd3,
        ST_SET_AL_HOUR = 3'd4,
        ST_SET_AL_MIN  = 3'd5
    } state_t;

    // Value a field takes after one increment, wrapping at max.
    function automatic logic [5:0] next_val(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and display outputs of the clock controller.
// master drives the events (button logic / bench), slave is the controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic                tick_1hz;
    logic                mode_p;
    logic                inc_p;
    logic                en;
    logic [HOUR_W-1:0]   hour;
    logic [MIN_W-1:0]    min;
    logic [SEC_W-1:0]    sec;
    logic [STATE_W-1:0]  mode;
    logic                blank;
    logic                chime_p;
    logic                alarm_on;

    modport master (
        output tick_1hz, mode_p, inc_p, en,
        input  hour, min, sec, mode, blank, chime_p, alarm_on
    );

    modport slave (
        input  tick_1hz, mode_p, inc_p, en,
        output hour, min, sec, mode, blank, chime_p, alarm_on
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up counter with synchronous load; wrap flags the MAX->0 step.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= (count_reg == W'(MAX)) ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign wrap  = inc && (count_reg == W'(MAX));

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with button set mode, blink phase and hourly chime.
// Define ALARM_EN to add the alarm time fields, their set states and alarm_on.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX   = 23,
    parameter int ALARM_SECS = 30
) (
    input  logic              clk,
    input  logic              rst,
    clock_set_ctrl_if.slave   bus
);

    state_t             state_reg, state_next;
    logic               phase_reg, phase_next;
    logic               chime_reg, chime_next;
    logic [HOUR_W-1:0]  hour_q;
    logic [MIN_W-1:0]   min_q;
    logic [SEC_W-1:0]   sec_q;
    logic               sec_inc, min_inc, hour_inc;
    logic               sec_wrap, min_wrap, hour_wrap;
    logic               run_tick, set_inc, alarm_on;
    logic               unused_wraps;

    // Carry chain kept as separate assigns so no block feeds itself.
    assign run_tick = (state_reg == ST_RUN) && bus.en && bus.tick_1hz;
    assign set_inc  = bus.inc_p && !bus.mode_p;
    assign sec_inc  = run_tick || ((state_reg == ST_SET_SEC) && set_inc);
    assign min_inc  = (run_tick && sec_wrap) || ((state_reg == ST_SET_MIN) && set_inc);
    assign hour_inc = (run_tick && min_wrap) || ((state_reg == ST_SET_HOUR) && set_inc);

    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .load(1'b0), .load_val('0),
        .count(sec_q), .wrap(sec_wrap)
    );
    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .load(1'b0), .load_val('0),
        .count(min_q), .wrap(min_wrap)
    );
    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .inc(hour_inc), .load(1'b0), .load_val('0),
        .count(hour_q), .wrap(hour_wrap)
    );

`ifdef ALARM_EN
    localparam int ACW = $clog2(ALARM_SECS + 1);

    logic [HOUR_W-1:0]  al_hour_q;
    logic [MIN_W-1:0]   al_min_q;
    logic               al_hour_wrap, al_min_wrap;
    logic               alarm_on_reg, alarm_hit;
    logic [ACW-1:0]     alarm_cnt_reg;
    logic [5:0]         nxt_min, nxt_hour;

    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_al_hour (
        .clk(clk), .rst(rst), .inc((state_reg == ST_SET_AL_HOUR) && set_inc),
        .load(1'b0), .load_val('0), .count(al_hour_q), .wrap(al_hour_wrap)
    );
    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_al_min (
        .clk(clk), .rst(rst), .inc((state_reg == ST_SET_AL_MIN) && set_inc),
        .load(1'b0), .load_val('0), .count(al_min_q), .wrap(al_min_wrap)
    );

    // The alarm fires on the tick whose result is al_hour:al_min:00.
    assign nxt_min   = next_val(6'(min_q), 6'(MIN_MAX));
    assign nxt_hour  = min_wrap ? next_val(6'(hour_q), 6'(HOUR_MAX)) : 6'(hour_q);
    assign alarm_hit = run_tick && sec_wrap && (nxt_min == 6'(al_min_q))
                       && (nxt_hour == 6'(al_hour_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_on_reg  <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (alarm_on_reg && (bus.mode_p || bus.inc_p)) begin
            alarm_on_reg  <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (alarm_hit) begin
            alarm_on_reg  <= 1'b1;
            alarm_cnt_reg <= ACW'(ALARM_SECS);
        end else if (alarm_on_reg && bus.tick_1hz) begin
            if (alarm_cnt_reg == ACW'(1)) begin
                alarm_on_reg  <= 1'b0;
                alarm_cnt_reg <= '0;
            end else begin
                alarm_cnt_reg <= alarm_cnt_reg - 1'b1;
            end
        end
    end

    assign alarm_on     = alarm_on_reg;
    assign unused_wraps = ^{hour_wrap, al_hour_wrap, al_min_wrap};
`else
    // Alarm duration has no meaning without the alarm feature.
    localparam int unused_alarm_secs = ALARM_SECS;

    assign alarm_on     = 1'b0;
    assign unused_wraps = hour_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            phase_reg <= 1'b0;
            chime_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            chime_reg <= chime_next;
        end
    end

    // A press that silences an active alarm does not change mode.
    always_comb begin
        state_next = state_reg;
        if (bus.mode_p && !alarm_on) begin
            unique case (state_reg)
                ST_RUN:         state_next = ST_SET_HOUR;
                ST_SET_HOUR:    state_next = ST_SET_MIN;
                ST_SET_MIN:     state_next = ST_SET_SEC;
`ifdef ALARM_EN
                ST_SET_SEC:     state_next = ST_SET_AL_HOUR;
                ST_SET_AL_HOUR: state_next = ST_SET_AL_MIN;
`else
                ST_SET_SEC:     state_next = ST_RUN;
`endif
                default:        state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        chime_next = run_tick && min_wrap;
        phase_next = phase_reg;
        if (state_next != state_reg) begin
            phase_next = 1'b0;
        end else if ((state_reg != ST_RUN) && bus.tick_1hz) begin
            phase_next = !phase_reg;
        end
    end

    assign bus.hour     = hour_q;
    assign bus.min      = min_q;
    assign bus.sec      = sec_q;
    assign bus.mode     = state_reg;
    assign bus.blank    = (state_reg != ST_RUN) && phase_reg;
    assign bus.chime_p  = chime_reg;
    assign bus.alarm_on = alarm_on;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; alarm scenarios run when ALARM_EN is defined.
module tb_clock_set_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    clock_set_ctrl_if bus_if ();

    clock_set_ctrl #(.HOUR_MAX(23), .ALARM_SECS(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One clock of stimulus: applied at a falling edge, results visible at the next.
    task automatic cyc(input logic t, input logic m, input logic i);
        bus_if.tick_1hz = t;
        bus_if.mode_p   = m;
        bus_if.inc_p    = i;
        @(negedge clk);
        bus_if.tick_1hz = 1'b0;
        bus_if.mode_p   = 1'b0;
        bus_if.inc_p    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int ah, input int am);
        cyc(0, 1, 0);
        repeat (h) cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (m) cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (s) cyc(0, 0, 1);
        cyc(0, 1, 0);
`ifdef ALARM_EN
        repeat (ah) cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (am) cyc(0, 0, 1);
        cyc(0, 1, 0);
`endif
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(bus_if.hour), 32'(h));
        check({tag, ".min"},  32'(bus_if.min),  32'(m));
        check({tag, ".sec"},  32'(bus_if.sec),  32'(s));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.tick_1hz = 1'b0;
        bus_if.mode_p   = 1'b0;
        bus_if.inc_p    = 1'b0;
        bus_if.en       = 1'b1;
        @(negedge clk);
        do_reset();

        check_time("reset", 0, 0, 0);
        check("reset.mode",     32'(bus_if.mode),     32'd0);
        check("reset.blank",    32'(bus_if.blank),    32'd0);
        check("reset.chime",    32'(bus_if.chime_p),  32'd0);
        check("reset.alarm_on", 32'(bus_if.alarm_on), 32'd0);

        // Rollover at end of day with the hourly chime.
        set_time(23, 59, 58, 0, 0);
        check("set.mode", 32'(bus_if.mode), 32'd0);
        check_time("set", 23, 59, 58);
        cyc(1, 0, 0);
        check_time("tick1", 23, 59, 59);
        check("tick1.chime", 32'(bus_if.chime_p), 32'd0);
        cyc(1, 0, 0);
        check_time("wrap", 0, 0, 0);
        check("wrap.chime", 32'(bus_if.chime_p), 32'd1);
        cyc(0, 0, 0);
        check("wrap.chime_after", 32'(bus_if.chime_p), 32'd0);

        // Pause holds time; run resumes counting.
        bus_if.en = 1'b0;
        repeat (5) cyc(1, 0, 0);
        check_time("paused", 0, 0, 0);
        bus_if.en = 1'b1;
        cyc(1, 0, 0);
        check("resume.sec", 32'(bus_if.sec), 32'd1);
        cyc(0, 0, 1);
        check("run_inc.sec", 32'(bus_if.sec), 32'd1);

        // Hour field edit wraps without touching other fields.
        cyc(0, 1, 0);
        check("set_hour.mode",  32'(bus_if.mode),  32'd1);
        check("set_hour.blank", 32'(bus_if.blank), 32'd0);
        repeat (25) cyc(0, 0, 1);
        check_time("hour25", 1, 0, 1);

        // mode_p beats inc_p in the same cycle.
        cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 1);
        check("set_min.min", 32'(bus_if.min), 32'd10);
        cyc(0, 1, 1);
        check("mode_inc.mode", 32'(bus_if.mode), 32'd3);
        check("mode_inc.min",  32'(bus_if.min),  32'd10);

        // Seconds wrap 59->0 in SET_SEC with no carry; ticks only blink.
        repeat (59) cyc(0, 0, 1);
        check_time("sec_wrap", 1, 10, 0);
        cyc(1, 0, 0);
        check("blink1", 32'(bus_if.blank), 32'd1);
        cyc(1, 0, 0);
        check("blink2", 32'(bus_if.blank), 32'd0);
        cyc(1, 0, 0);
        check("blink3", 32'(bus_if.blank), 32'd1);
        check("blink.sec", 32'(bus_if.sec), 32'd0);
        cyc(0, 1, 0);
`ifdef ALARM_EN
        check("after_sec.mode",  32'(bus_if.mode),  32'd4);
        check("after_sec.blank", 32'(bus_if.blank), 32'd0);
        cyc(0, 1, 0);
        check("al_min.mode", 32'(bus_if.mode), 32'd5);
        cyc(0, 1, 0);
`endif
        check("back_run.mode",  32'(bus_if.mode),  32'd0);
        check("back_run.blank", 32'(bus_if.blank), 32'd0);

        // Reset overrides simultaneous presses mid-set.
        cyc(0, 1, 0);
        check("pre_rst.mode", 32'(bus_if.mode), 32'd1);
        rst = 1'b1;
        bus_if.tick_1hz = 1'b1;
        bus_if.mode_p   = 1'b1;
        bus_if.inc_p    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.tick_1hz = 1'b0;
        bus_if.mode_p   = 1'b0;
        bus_if.inc_p    = 1'b0;
        check("rst_mid.mode", 32'(bus_if.mode), 32'd0);
        check_time("rst_mid", 0, 0, 0);
        check("rst_mid.alarm_on", 32'(bus_if.alarm_on), 32'd0);

`ifdef ALARM_EN
        // Alarm fires at 07:00:00 and holds for 30 ticks.
        do_reset();
        set_time(6, 59, 59, 7, 0);
        cyc(1, 0, 0);
        check("alarm.on", 32'(bus_if.alarm_on), 32'd1);
        check_time("alarm", 7, 0, 0);
        repeat (29) cyc(1, 0, 0);
        check("alarm.29", 32'(bus_if.alarm_on), 32'd1);
        cyc(1, 0, 0);
        check("alarm.30", 32'(bus_if.alarm_on), 32'd0);

        // inc_p silences early and is otherwise consumed.
        do_reset();
        set_time(6, 59, 59, 7, 0);
        cyc(1, 0, 0);
        repeat (3) cyc(1, 0, 0);
        check("alarm_inc.before", 32'(bus_if.alarm_on), 32'd1);
        cyc(0, 0, 1);
        check("alarm_inc.off", 32'(bus_if.alarm_on), 32'd0);
        check_time("alarm_inc", 7, 0, 3);

        // mode_p silences and does not enter set mode.
        do_reset();
        set_time(6, 59, 59, 7, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        check("alarm_mode.off",  32'(bus_if.alarm_on), 32'd0);
        check("alarm_mode.mode", 32'(bus_if.mode),     32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
